// File: rtl/light_pattern_sequencer.sv
// rtl/light_pattern_sequencer.sv - pattern source feeding the light-dance shift register
// Emits one load/pdata window followed by HOLD_CYCLES serial din cycles, ROM or host pattern.
module light_pattern_sequencer #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] user_pattern,
    input  logic             user_valid,
    output logic             user_ready,
    output logic             load,
    output logic [WIDTH-1:0] pdata,
    output logic             din,
    output logic             busy,
    output logic [1:0]       pat_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             toggle, toggle_d;
    logic [7:0]       lfsr, lfsr_d;
    logic [WIDTH-1:0] ubuf, ubuf_d;
    logic             ready_d;
    logic             load_d, din_d, busy_d;
    logic [WIDTH-1:0] pdata_d;
    logic [1:0]       idx_d;
    logic             start_load, emit;

    function automatic logic [WIDTH-1:0] rom(input logic [1:0] i);
        case (i)
            2'd0:    return WIDTH'(8'h55);
            2'd1:    return WIDTH'(8'h77);
            2'd2:    return WIDTH'(8'h0F);
            default: return WIDTH'(8'h81);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= IDLE;
            cnt        <= '0;
            mode_q     <= 2'd0;
            toggle     <= 1'b0;
            lfsr       <= 8'h01;
            ubuf       <= '0;
            user_ready <= 1'b1;
            load       <= 1'b0;
            pdata      <= '0;
            din        <= 1'b0;
            busy       <= 1'b0;
            pat_idx    <= 2'd0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            mode_q     <= mode_d;
            toggle     <= toggle_d;
            lfsr       <= lfsr_d;
            ubuf       <= ubuf_d;
            user_ready <= ready_d;
            load       <= load_d;
            pdata      <= pdata_d;
            din        <= din_d;
            busy       <= busy_d;
            pat_idx    <= idx_d;
        end
    end

    // Outputs are computed for the state being entered, so they register alongside it.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        mode_d     = mode_q;
        toggle_d   = toggle;
        lfsr_d     = lfsr;
        ubuf_d     = ubuf;
        ready_d    = user_ready;
        load_d     = 1'b0;
        pdata_d    = pdata;
        din_d      = 1'b0;
        busy_d     = busy;
        idx_d      = pat_idx;
        start_load = 1'b0;
        emit       = 1'b0;

        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (enable) start_load = 1'b1;
            end
            LOAD: begin
                if (enable) begin
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                    emit    = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (!enable) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt == '0) begin
                    start_load = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // cnt holds the number of shift cycles still to be emitted in this window
        if (emit) begin
            cnt_d    = cnt - CNT_W'(1);
            toggle_d = ~toggle;
            case (mode_q)
                2'd0: din_d = 1'b0;
                2'd1: din_d = 1'b1;
                2'd2: din_d = toggle;
                default: begin
                    din_d  = lfsr[7];
                    lfsr_d = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                end
            endcase
        end

        if (start_load) begin
            state_d  = LOAD;
            load_d   = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(HOLD_CYCLES);
            toggle_d = 1'b0;
            mode_d   = mode;
            if (!user_ready) begin
                pdata_d = ubuf;
                ready_d = 1'b1;
            end else begin
                pdata_d = rom(pat_idx);
                idx_d   = pat_idx + 2'd1;
            end
        end

        // Capture only happens into an empty buffer, so it never collides with a consume.
        if (user_valid && user_ready) begin
            ubuf_d  = user_pattern;
            ready_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_light_pattern_sequencer.sv
// tb/tb_light_pattern_sequencer.sv - scoreboard bench for light_pattern_sequencer
module tb_light_pattern_sequencer;

    localparam int W = 8;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         arst;
    logic         enable;
    logic [1:0]   mode;
    logic [W-1:0] user_pattern;
    logic         user_valid;
    logic         user_ready;
    logic         load;
    logic [W-1:0] pdata;
    logic         din;
    logic         busy;
    logic [1:0]   pat_idx;

    light_pattern_sequencer #(.WIDTH(W), .HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk          (clk),
        .arst         (arst),
        .enable       (enable),
        .mode         (mode),
        .user_pattern (user_pattern),
        .user_valid   (user_valid),
        .user_ready   (user_ready),
        .load         (load),
        .pdata        (pdata),
        .din          (din),
        .busy         (busy),
        .pat_idx      (pat_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pdata;
        logic [1:0] idx;
        logic [7:0] dins;
        bit         chk_din;
        bit         b2b;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic push(input logic [7:0] p, input logic [1:0] i, input logic [7:0] d,
                        input bit chk_din, input bit b2b);
        exp_t e;
        e.pdata = p; e.idx = i; e.dins = d; e.chk_din = chk_din; e.b2b = b2b;
        sbq.push_back(e);
    endtask

    // {load, pdata, din, busy, user_ready, pat_idx} in the reset state
    function automatic logic [31:0] out_vec();
        return {18'd0, load, pdata, din, busy, user_ready, pat_idx};
    endfunction
    localparam logic [31:0] RESET_VEC = {18'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0};

    // Monitor: pops an expectation on every load pulse, then collects the window's din stream.
    initial begin : monitor
        exp_t       cur;
        bit         active;
        int         nbits;
        int         last_load;
        logic [7:0] got;
        active = 0; nbits = 0; last_load = -100; got = '0;
        cur.pdata = '0; cur.idx = '0; cur.dins = '0; cur.chk_din = 0; cur.b2b = 0;
        forever begin
            @(negedge clk);
            if (arst) begin
                active = 0;
            end else if (load) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_load: got pdata 0x%0h with empty scoreboard", pdata);
                    active = 0;
                end else begin
                    cur = sbq.pop_front();
                    check("load_pdata", pdata, cur.pdata);
                    check("load_pat_idx", pat_idx, cur.idx);
                    if (cur.b2b) check("window_period", cyc - last_load, H + 1);
                    active = 1; nbits = 0; got = '0;
                end
                last_load = cyc;
            end else if (active && busy) begin
                got = {got[6:0], din};
                nbits++;
                if (nbits == H) begin
                    active = 0;
                    if (cur.chk_din) check("din_stream", got, cur.dins);
                end
            end else begin
                active = 0;
            end
        end
    end

    task automatic wait_load(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (load) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL wait_load: no load within 40 cycles, got busy %0b", busy);
        end
    endtask

    // Back-to-back windows; enable drops during the last LOAD so that window never shifts.
    task automatic run_windows(input int n, input logic [1:0] m);
        bit ok;
        enable = 1'b1;
        mode   = m;
        for (int k = 0; k < n; k++) begin
            wait_load(ok);
            if (!ok) break;
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // One full window; mode is scrambled mid-shift to show it is held from LOAD.
    task automatic one_window(input logic [1:0] m);
        bit ok;
        enable = 1'b1;
        mode   = m;
        wait_load(ok);
        mode = ~m;
        repeat (H) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("idle_after_window", {busy, load, din}, 3'b000);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        bit ok;
        arst = 1'b1; enable = 1'b0; mode = 2'd0; user_pattern = '0; user_valid = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle_outputs", out_vec(), RESET_VEC);
        end

        // ROM walk with wrap
        push(8'h55, 2'd1, 8'h00, 1, 0);
        push(8'h77, 2'd2, 8'h00, 1, 1);
        push(8'h0F, 2'd3, 8'h00, 1, 1);
        push(8'h81, 2'd0, 8'h00, 1, 1);
        push(8'h55, 2'd1, 8'h00, 0, 1);
        run_windows(5, 2'd0);

        // Serial modes
        push(8'h77, 2'd2, 8'h55, 1, 0);
        one_window(2'd2);
        push(8'h0F, 2'd3, 8'h01, 1, 0);
        one_window(2'd3);
        push(8'h81, 2'd0, 8'hFF, 1, 0);
        one_window(2'd1);

        // Host pattern from a fresh reset
        arst = 1'b1;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        user_pattern = 8'hA5; user_valid = 1'b1;
        @(negedge clk);
        user_valid = 1'b0;
        check("user_ready_after_capture", user_ready, 1'b0);
        check("idle_pdata_unchanged", pdata, 8'h00);
        push(8'hA5, 2'd0, 8'h00, 1, 0);
        push(8'h55, 2'd1, 8'h00, 0, 1);
        enable = 1'b1; mode = 2'd0;
        wait_load(ok);
        check("user_ready_after_consume", user_ready, 1'b1);
        wait_load(ok);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Abort on the 4th shift cycle, then resume at the next ROM entry
        push(8'h77, 2'd2, 8'h00, 0, 0);
        enable = 1'b1; mode = 2'd1;
        wait_load(ok);
        repeat (4) @(negedge clk);
        check("din_before_abort", din, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_outputs", {busy, load, din}, 3'b000);
        check("abort_pat_idx", pat_idx, 2'd2);
        repeat (2) @(negedge clk);
        push(8'h0F, 2'd3, 8'h00, 1, 0);
        one_window(2'd0);

        // Reset on the 5th shift cycle with the host buffer full
        push(8'h81, 2'd0, 8'h00, 0, 0);
        enable = 1'b1; mode = 2'd1;
        wait_load(ok);
        @(negedge clk);
        user_pattern = 8'h3C; user_valid = 1'b1;
        @(negedge clk);
        user_valid = 1'b0;
        check("buffer_full_mid_window", user_ready, 1'b0);
        repeat (3) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        check("reset_mid_window_outputs", out_vec(), RESET_VEC);
        arst = 1'b0; enable = 1'b0;
        @(negedge clk);
        push(8'h55, 2'd1, 8'h00, 1, 0);
        one_window(2'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/light_pattern_sequencer.md
Name: light_pattern_sequencer

Overview:
- Upstream pattern source for the light-dance shift register.
- Cycles through a fixed 4-entry pattern ROM, or through host-supplied one-shot patterns.
- Each pattern window is one `load` pulse with `pdata`, followed by HOLD_CYCLES shift cycles.
- During the shift cycles, the serial `din` stream follows the selected mode.
- Outputs connect directly to the downstream `load` / `pdata` / `din` inputs.

Parameters:
- WIDTH, 8, pattern width; ROM entries and `user_pattern` are this width.
- HOLD_CYCLES, 8, shift cycles per pattern window; legal range 1..255.
- CNT_W, 8, width of the shift counter; must hold HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- arst  input  1  reset, synchronous, active-high.
- enable  input  1  run request; level-sensitive.
- mode  input  2  din source: 0 = constant 0, 1 = constant 1, 2 = toggle, 3 = LFSR.
- user_pattern  input  WIDTH  host pattern.
- user_valid  input  1  host offers `user_pattern`.
- user_ready  output  1  one-entry buffer empty; transfer occurs when `user_valid & user_ready`.
- load  output  1  one-cycle parallel-load strobe.
- pdata  output  WIDTH  pattern presented with `load`.
- din  output  1  serial shift-in bit.
- busy  output  1  high in LOAD or SHIFT.
- pat_idx  output  2  ROM index of the next ROM pattern.

Behaviour:
- All outputs are registered.
- Reset, sampled only on the clk edge, and with priority over everything else:
  - state = IDLE; load = 0, pdata = 0, din = 0, busy = 0, pat_idx = 0.
  - shift counter = 0, toggle bit = 0, lfsr = 8'h01.
  - user buffer cleared, so user_ready = 1.
- Reset asserted mid-window aborts that window at the same edge.
- ROM contents: idx0 = 8'h55, idx1 = 8'h77, idx2 = 8'h0F, idx3 = 8'h81.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: load = 0, din = 0, busy = 0, pdata holds its last value. If enable = 1 at an edge, go to LOAD at that edge.
  - LOAD (exactly 1 cycle): load = 1, busy = 1.
    - If the user buffer is full: pdata = buffered pattern, buffer cleared, pat_idx unchanged.
    - Otherwise: pdata = ROM[pat_idx], then pat_idx increments, wrapping 3 -> 0.
    - `mode` is sampled here and held for the whole window.
    - Shift counter loads HOLD_CYCLES; toggle bit resets to 0. The LFSR is not reset here.
  - SHIFT: load = 0, busy = 1, pdata holds.
    - Each cycle, din takes the held mode's value:
      - mode 0: din = 0.
      - mode 1: din = 1.
      - mode 2: din = toggle; the toggle bit inverts each cycle, so the stream is 0, 1, 0, 1, ...
      - mode 3: din = lfsr[7]; lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. The LFSR advances only in mode-3 SHIFT cycles.
    - The counter decrements each cycle. After HOLD_CYCLES SHIFT cycles:
      - if enable = 1, go to LOAD (back-to-back windows);
      - otherwise go to IDLE.
- Window period is HOLD_CYCLES + 1 cycles. First load comes 1 cycle after enable is sampled high.
- enable falling during SHIFT: at the next edge go to IDLE with din = 0 and load = 0. The window is abandoned and pat_idx is retained, so the next run resumes at the next ROM index.
- enable falling during LOAD: LOAD still completes (load pulse is never truncated), then IDLE.
- User handshake:
  - user_ready = !buffer_full.
  - Capture happens at an edge where `user_valid & user_ready`.
  - Capture and consume in the same LOAD cycle: LOAD uses the old buffer content (or ROM if it was empty), and the new value is captured for the next window.
  - A buffered pattern survives IDLE; only reset clears it.
- mode changes mid-SHIFT are ignored until the next LOAD.

Test Plan:
- Reset then idle: arst = 1 for 3 cycles, then enable = 0 for 10 cycles -> load = 0, pdata = 0, din = 0, busy = 0, user_ready = 1, pat_idx = 0 throughout.
- ROM sequence: enable = 1, mode = 0 -> load pulses every 9 cycles with pdata 0x55, 0x77, 0x0F, 0x81, 0x55 (wrap); din = 0 throughout; pat_idx steps 1, 2, 3, 0, 1.
- Serial modes:
  - mode = 2 window -> din = 0, 1, 0, 1, 0, 1, 0, 1.
  - First mode = 3 window after reset -> din = 0, 0, 0, 0, 0, 0, 0, 1.
  - mode = 1 -> eight 1s.
- User pattern: offer 0xA5 with user_valid while idle -> user_ready drops after capture; enable -> first load shows pdata = 0xA5 and pat_idx stays 0; next load shows 0x55; user_ready returns high after the consuming LOAD.
- Abort and resume: enable low on the 4th SHIFT cycle of the 0x77 window -> IDLE next edge with din = 0 and busy = 0; re-enable -> next load pdata = 0x0F.
- Reset mid-window: arst on the 5th SHIFT cycle with the user buffer full -> all outputs at reset values next edge; buffer cleared; next run starts with 0x55.
